// File: rtl/spi_slave_regif_pkg.sv
// spi_slave_regif_pkg: frame constants, FSM states and helpers for the SPI register front end
package spi_slave_regif_pkg;
  localparam int FRAME_BITS = 48;
  localparam int HDR_BITS = 16;
  localparam logic SPI_RW_WRITE = 1'b1;
  typedef enum logic [2:0] {WAIT_CS_HIGH, IDLE, HEADER, WRITE_DATA, READ_DATA, DONE} state_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/spi_slave_regif_if.sv
// spi_slave_regif_if: SPI pins plus the register-map side bus of the SPI slave
interface spi_slave_regif_if;
  logic spi_sclk, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
  logic [15:0] addr;
  logic [31:0] data_mosi, data_miso;
  logic data_mosi_rdy, rd_req;
  logic [7:0] frame_err_cnt;
  modport slave (
    input spi_sclk, spi_cs_n, spi_mosi, data_miso,
    output spi_miso, spi_miso_oe, addr, data_mosi, data_mosi_rdy, rd_req, frame_err_cnt
  );
  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, data_miso,
    input spi_miso, spi_miso_oe, addr, data_mosi, data_mosi_rdy, rd_req, frame_err_cnt
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses on the synchronized level
module spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh <= {(STAGES + 1){INIT}};
    else sh <= {sh[STAGES-1:0], d};
  assign q = sh[STAGES-1];
  assign rise = sh[STAGES-1] & ~sh[STAGES];
  assign fall = ~sh[STAGES-1] & sh[STAGES];
endmodule

// File: rtl/spi_slave_regif.sv
// spi_slave_regif: oversampled SPI mode-0 slave decoding 48-bit frames into register writes and reads
module spi_slave_regif
  import spi_slave_regif_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY = 2
) (
  input logic clk_100m,
  input logic rst_n_syn,
  spi_slave_regif_if.slave bus
);
  state_t state;
  logic [5:0] cnt;
  logic [31:0] shreg;
  logic [2:0] rd_cnt;
  logic err_seen;
  logic sclk_q, sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi_q, mosi_rise, mosi_fall;
  logic unused_ok;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk(clk_100m), .rst_n(rst_n_syn), .d(bus.spi_sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk(clk_100m), .rst_n(rst_n_syn), .d(bus.spi_cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clk(clk_100m), .rst_n(rst_n_syn), .d(bus.spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused_ok = ^{sclk_q, cs_rise, mosi_rise, mosi_fall};
  assign bus.spi_miso_oe = ~cs_q;
  // cnt also times out the reset-valued synchronizer contents before CS is trusted in WAIT_CS_HIGH
  always_ff @(posedge clk_100m or negedge rst_n_syn)
    if (!rst_n_syn) begin
      state <= WAIT_CS_HIGH;
      cnt <= '0;
      shreg <= '0;
      rd_cnt <= '0;
      err_seen <= 1'b0;
      bus.addr <= '0;
      bus.data_mosi <= '0;
      bus.data_mosi_rdy <= 1'b0;
      bus.rd_req <= 1'b0;
      bus.spi_miso <= 1'b0;
      bus.frame_err_cnt <= '0;
    end else begin
      bus.data_mosi_rdy <= 1'b0;
      bus.rd_req <= 1'b0;
      if (bus.rd_req) rd_cnt <= 3'(RD_LATENCY);
      else if (rd_cnt != 3'd0) rd_cnt <= rd_cnt - 3'd1;
      case (state)
        WAIT_CS_HIGH:
          if (cnt < 6'(SYNC_STAGES)) cnt <= cnt + 6'd1;
          else if (cs_q) state <= IDLE;
        IDLE:
          if (cs_fall) begin
            state <= HEADER;
            cnt <= '0;
            err_seen <= 1'b0;
          end
        HEADER, WRITE_DATA:
          if (cs_q) begin
            state <= IDLE;
            bus.frame_err_cnt <= sat_inc(bus.frame_err_cnt);
          end else if (sclk_rise) begin
            shreg <= {shreg[30:0], mosi_q};
            cnt <= cnt + 6'd1;
            if (state == HEADER && cnt == 6'(HDR_BITS - 1)) begin
              bus.addr <= {1'b0, shreg[13:0], mosi_q};
              state <= (shreg[14] == SPI_RW_WRITE) ? WRITE_DATA : READ_DATA;
              bus.rd_req <= (shreg[14] != SPI_RW_WRITE);
            end else if (state == WRITE_DATA && cnt == 6'(FRAME_BITS - 1)) begin
              bus.data_mosi <= {shreg[30:0], mosi_q};
              bus.data_mosi_rdy <= 1'b1;
              state <= DONE;
            end
          end
        READ_DATA:
          if (cs_q) begin
            state <= IDLE;
            bus.spi_miso <= 1'b0;
            bus.frame_err_cnt <= sat_inc(bus.frame_err_cnt);
          end else if (sclk_rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(FRAME_BITS - 1)) begin
              state <= DONE;
              bus.spi_miso <= 1'b0;
            end
          end else if (sclk_fall) begin
            bus.spi_miso <= shreg[31];
            shreg <= {shreg[30:0], 1'b0};
          end else if (rd_cnt == 3'd1) shreg <= bus.data_miso;
        DONE:
          if (cs_q) state <= IDLE;
          else if (sclk_rise && !err_seen) begin
            err_seen <= 1'b1;
            bus.frame_err_cnt <= sat_inc(bus.frame_err_cnt);
          end
        default: state <= WAIT_CS_HIGH;
      endcase
    end
endmodule
